// File: rtl/writeback_scheduler.sv
// rtl/writeback_scheduler.sv - writeback mux sequencing controller
// Captures one request, waits on IO or data memory when needed, then issues a single register write.
module writeback_scheduler #(
  parameter int MEM_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [2:0] op_sel,
  input  logic       op_wen,
  input  logic [4:0] op_dest,
  input  logic       io_valid,
  output logic       op_ready,
  output logic [2:0] regdatain,
  output logic       reg_write,
  output logic [4:0] reg_waddr,
  output logic       io_ack,
  output logic       stall,
  output logic       op_done,
  output logic       illegal
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IO  = 2'd1,
    WAIT_MEM = 2'd2,
    WRITE    = 2'd3
  } state_t;

  localparam logic [3:0] MEM_LOAD = 4'(MEM_LATENCY - 1);

  state_t     state;
  logic [3:0] mem_cnt;
  logic       wen_q;
  logic       sel_legal;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      mem_cnt   <= 4'd0;
      wen_q     <= 1'b0;
      regdatain <= 3'd0;
      reg_waddr <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            regdatain <= op_sel;
            reg_waddr <= op_dest;
            wen_q     <= op_wen;
            // Only requests that really write need to wait for their slow source.
            if (op_wen && op_sel == 3'b000) begin
              state <= WAIT_IO;
            end else if (op_wen && op_sel == 3'b011) begin
              state   <= WAIT_MEM;
              mem_cnt <= MEM_LOAD;
            end else begin
              state <= WRITE;
            end
          end
        end
        WAIT_IO: begin
          if (io_valid) state <= WRITE;
        end
        WAIT_MEM: begin
          if (mem_cnt == 4'd0) state <= WRITE;
          else mem_cnt <= mem_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel_legal = !(regdatain[2] && regdatain[1]);
  assign op_ready  = (state == IDLE);
  assign stall     = (state != IDLE);
  assign op_done   = (state == WRITE);
  assign illegal   = (state == WRITE) && !sel_legal;
  assign reg_write = (state == WRITE) && wen_q && sel_legal && (reg_waddr != 5'd0);
  // The only combinational path from an input: IO data is consumed in the cycle it appears.
  assign io_ack    = (state == WAIT_IO) && io_valid;

endmodule

// File: doc/writeback_scheduler.md
# writeback_scheduler

Sequencing controller for the register-bank writeback multiplexer. Accepts one writeback request at a time from the decode/control logic, drives the 3-bit writeback source select (`regdatain`), waits for multi-cycle sources (IO unit, data memory), then issues a single-cycle register write. It stalls the rest of the pipeline while a request is pending.

## Interface
Parameters:
- `MEM_LATENCY`, default 1: cycles from request acceptance until data memory output is valid. Legal range 1..15.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  writeback request present.
- `op_sel`  in  3  source code: 000 IO, 001 PC+1, 010 rs data, 011 data mem out, 100 ALU out, 101 16-bit extender, 110/111 illegal.
- `op_wen`  in  1  request actually writes the register bank.
- `op_dest`  in  5  destination register index.
- `io_valid`  in  1  IO unit holds valid input data.
- `op_ready`  out  1  controller can accept a request this cycle.
- `regdatain`  out  3  select to writeback mux.
- `reg_write`  out  1  register bank write enable.
- `reg_waddr`  out  5  register bank write address.
- `io_ack`  out  1  one-cycle pulse consuming IO data.
- `stall`  out  1  freeze PC/pipeline.
- `op_done`  out  1  one-cycle pulse: request retired.
- `illegal`  out  1  one-cycle pulse with `op_done` when `op_sel` was 110/111.

## Operation
- Handshake: request accepted on a rising edge where `op_valid && op_ready`. `op_ready` = 1 only in IDLE. `op_valid` outside IDLE is ignored; the requester holds it.
- On acceptance: capture `op_sel` into `regdatain`, `op_dest` into `reg_waddr`, `op_wen` into an internal flag. Captured values are held unchanged until the next acceptance.
- States:
  - IDLE: `op_ready`=1, `stall`=0. On acceptance: sel 000 with wen=1 -> WAIT_IO; sel 011 with wen=1 -> WAIT_MEM, load counter with `MEM_LATENCY`-1; otherwise -> WRITE.
  - WAIT_IO: `stall`=1. When `io_valid`=1: `io_ack`=1 in that cycle, go to WRITE. Otherwise stay, with no timeout.
  - WAIT_MEM: `stall`=1. Decrement the counter each cycle. At 0 go to WRITE.
  - WRITE: `stall`=1, `op_done`=1. `reg_write`=1 only if captured wen=1, dest != 0, and sel is legal. Next state is IDLE.
- Writes to register 0 are suppressed, but the request still retires normally.
- Illegal sel: no write, no wait, `illegal`=1 in WRITE.
- wen=0 with sel 000 or 011: no wait, no `io_ack`; retires via WRITE.
- `io_valid` while not in WAIT_IO: ignored, no `io_ack`.
- Reset mid-operation: request abandoned, no write, no `op_done`.

## Timing
- Reset values: state IDLE, `regdatain`=000, `reg_waddr`=0, `reg_write`=0, `io_ack`=0, `op_done`=0, `illegal`=0, `stall`=0, `op_ready`=1.
- All outputs are decoded from registered state and captured fields. `io_ack` is the only output that depends combinationally on an input (`io_valid`).
- Request accepted at edge N (state enters the next state at N):
  - Direct sources (001/010/100/101), wen=0, or illegal: WRITE occupies cycle N..N+1; `reg_write` high for that one cycle; IDLE at N+1; next acceptance possible at edge N+2.
  - Mem: WAIT_MEM for `MEM_LATENCY` cycles, then one WRITE cycle. `MEM_LATENCY`=1 gives `reg_write` in cycle N+1..N+2.
  - IO: `io_valid` seen in cycle K gives `io_ack` in cycle K and WRITE in the following cycle.
- Maximum throughput: one request every 2 cycles.
- `regdatain` and `reg_waddr` are stable for the whole pending period, including the WRITE cycle.

## Test plan
- Reset, then `op_valid`=1, sel=100, dest=5, wen=1 -> `regdatain`=100 the cycle after the edge; `reg_write`=1, `reg_waddr`=5, `op_done`=1 for exactly one cycle; `op_ready` back to 1 the next cycle.
- sel=011, dest=7, `MEM_LATENCY`=3 -> `stall`=1 for 3 WAIT_MEM cycles plus WRITE; `reg_write` pulses 4 cycles after acceptance; a second `op_valid` held throughout is accepted only once IDLE is reached.
- sel=000, dest=2, `io_valid` held low for 10 cycles then raised -> `stall` stays 1 for the whole wait; `io_ack` high exactly in the `io_valid` cycle; `reg_write` on the following cycle; `io_valid` pulsed while IDLE gives no `io_ack`.
- dest=0 with sel=001, and separately sel=110 -> `op_done` pulses with `reg_write`=0; the sel=110 case also pulses `illegal`=1.
- Reset asserted during WAIT_IO and during WAIT_MEM -> next cycle all outputs at reset values, no `reg_write` or `op_done` ever seen for the abandoned request.
- Back-to-back direct requests with `op_valid` held high -> one `op_done` every 2 cycles; `regdatain` follows each captured sel.
